// File: rtl/mod12_sched_pkg.sv
// Shared types and constants for the mod-12 counter scheduler.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mod12_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int MOD_N   = 12;
    localparam int MAX_VAL = 11;

    // Any start value the counter cannot represent is replaced by 0.
    function automatic logic [3:0] clamp_start(input logic [3:0] v);
        return (v >= 4'(MOD_N)) ? 4'd0 : v;
    endfunction

endpackage

// File: rtl/mod12_count_scheduler_if.sv
// Requester-side bus of the mod-12 counter scheduler: requests in, grants and run results out.
// Latency: wires only.
// Backpressure: a requester holds req until it sees its gnt pulse.
interface mod12_count_scheduler_if #(
    parameter int NREQ  = 4,
    parameter int LEN_W = 4
);
    logic [NREQ-1:0]       req;
    logic [NREQ*4-1:0]     req_start;
    logic [NREQ*LEN_W-1:0] req_len;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic                  done;
    logic [2:0]            done_id;
    logic [3:0]            end_val;
    logic                  start_err;

    modport master (
        output req, req_start, req_len,
        input  gnt, busy, done, done_id, end_val, start_err
    );

    modport slave (
        input  req, req_start, req_len,
        output gnt, busy, done, done_id, end_val, start_err
    );
endinterface

// File: rtl/mod12_count_scheduler_rr_arbiter.sv
// Picks one requester: round-robin from ptr, or lowest index when MOD12_SCHED_FIXED_PRIO_EN is defined.
// Latency: purely combinational.
// Backpressure: none; a requester not picked simply stays unserved this cycle.
module rr_arbiter_nreq #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] req,
    input  logic [2:0]      ptr,
    output logic [NREQ-1:0] gnt,
    output logic [2:0]      idx,
    output logic            any
);
    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    int                pos;

    assign dbl = {req, req};

    // Rotate so the highest-priority requester sits at bit 0, then take the first set bit.
    always_comb begin
        rot = '0;
        pos = 0;
        any = 1'b0;
        idx = '0;
        gnt = '0;
`ifdef MOD12_SCHED_FIXED_PRIO_EN
        rot = req;
`else
        rot = NREQ'(dbl >> ptr);
`endif
        for (int k = 0; k < NREQ; k++) begin
            if (!any && rot[k]) begin
                any = 1'b1;
`ifdef MOD12_SCHED_FIXED_PRIO_EN
                pos = k;
`else
                pos = (int'(ptr) + k) % NREQ;
`endif
            end
        end
        if (any) begin
            idx = 3'(pos);
            gnt = NREQ'(1) << idx;
        end
    end
endmodule

// File: rtl/mod12_counter.sv
// Loadable mod-12 up counter: loads data when load_en=1, otherwise counts 0..11 and wraps.
// Latency: q reflects a load or increment one cycle after the edge that samples it.
// Backpressure: none; holding requires load_en=1 with data=q.
module mod12_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_en,
    input  logic [3:0] data,
    output logic [3:0] q
);
    logic [3:0] q_q;
    logic [3:0] q_d;

    // Next value: load, or increment with wrap from 11 back to 0.
    always_comb begin
        q_d = q_q;
        if (load_en) begin
            q_d = data;
        end else if (q_q >= 4'd11) begin
            q_d = 4'd0;
        end else begin
            q_d = q_q + 4'd1;
        end
    end

    // Counter register with synchronous reset to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= 4'd0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;
endmodule

// File: rtl/mod12_count_scheduler.sv
// Time-shares one mod-12 counter: grant a request, load its start, run LEN cycles, report end value.
// Latency: gnt in the same cycle a request is seen in IDLE; done len+2 cycles after gnt.
// Backpressure: requests arriving while busy wait (held level) until the block returns to IDLE.
// Arbitration mode: MOD12_SCHED_FIXED_PRIO_EN selects fixed lowest-index priority.
module mod12_count_scheduler
    import mod12_sched_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int LEN_W = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    mod12_count_scheduler_if.slave  bus,
    output logic                    cnt_load_en,
    output logic [3:0]              cnt_data,
    input  logic [3:0]              cnt_q
);
    state_t             state_q, state_d;
    logic [2:0]         ptr_q, ptr_d;
    logic [2:0]         id_q, id_d;
    logic [3:0]         start_q, start_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   run_q, run_d;
    logic [2:0]         done_id_q, done_id_d;
    logic [3:0]         end_val_q, end_val_d;

    logic [NREQ-1:0]    arb_gnt;
    logic [2:0]         arb_idx;
    logic               arb_any;
    logic [3:0]         raw_start;
    logic [LEN_W-1:0]   raw_len;
    logic [NREQ-1:0]    gnt;
    logic               start_err;
    logic               done;

    rr_arbiter_nreq #(.NREQ(NREQ)) u_arb (
        .req (bus.req),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    // Pick out the winning requester's start and length fields.
    always_comb begin
        raw_start = '0;
        raw_len   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_idx == 3'(i)) begin
                raw_start = bus.req_start[4*i +: 4];
                raw_len   = bus.req_len[LEN_W*i +: LEN_W];
            end
        end
    end

    // Next-state and outputs; the counter reloads its own value whenever it must not advance.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        start_d     = start_q;
        len_d       = len_q;
        run_d       = run_q;
        done_id_d   = done_id_q;
        end_val_d   = end_val_q;
        gnt         = '0;
        start_err   = 1'b0;
        done        = 1'b0;
        cnt_load_en = 1'b1;
        cnt_data    = cnt_q;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    gnt       = arb_gnt;
                    start_err = (raw_start >= 4'(MOD_N));
                    id_d      = arb_idx;
                    start_d   = clamp_start(raw_start);
                    len_d     = raw_len;
                    ptr_d     = (arb_idx == 3'(NREQ-1)) ? 3'd0 : arb_idx + 3'd1;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                cnt_data = start_q;
                if (len_q == '0) begin
                    state_d = DONE;
                end else begin
                    run_d   = len_q;
                    state_d = RUN;
                end
            end
            RUN: begin
                cnt_load_en = 1'b0;
                if (run_q == LEN_W'(1)) begin
                    state_d = DONE;
                end else begin
                    run_d = run_q - LEN_W'(1);
                end
            end
            DONE: begin
                done      = 1'b1;
                done_id_d = id_q;
                end_val_d = cnt_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and context registers; reset mid-run abandons the run silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            id_q      <= '0;
            start_q   <= '0;
            len_q     <= '0;
            run_q     <= '0;
            done_id_q <= '0;
            end_val_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            id_q      <= id_d;
            start_q   <= start_d;
            len_q     <= len_d;
            run_q     <= run_d;
            done_id_q <= done_id_d;
            end_val_q <= end_val_d;
        end
    end

    assign bus.gnt       = gnt;
    assign bus.start_err = start_err;
    assign bus.done      = done;
    assign bus.busy      = (state_q != IDLE);
    // Result fields are live during DONE and hold their last value otherwise.
    assign bus.done_id   = done ? id_q : done_id_q;
    assign bus.end_val   = done ? cnt_q : end_val_q;
endmodule
